// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing unit.
// Holds the FSM state encoding, the mult/div latency default and the
// register-zero constant, plus a small operand-match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_HOLD = 2'd2
  } state_e;

  localparam int         MD_LATENCY_DEF = 8;
  localparam int         MD_CNT_W       = 4;
  localparam logic [4:0] REG_ZERO       = 5'd0;

  // True when the ID instruction actually reads a register equal to the EX destination.
  function automatic logic reg_match(input logic uses, input logic [4:0] id_reg,
                                     input logic [4:0] ex_reg);
    return uses && (id_reg == ex_reg);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-control outputs.
// The master side is the pipeline (drives hazard info, receives enables),
// the slave side is the hazard controller itself.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IdRs;
  logic [4:0]       IdRt;
  logic             IdUsesRs;
  logic             IdUsesRt;
  logic             IdMdRead;
  logic             ExMemRead;
  logic [4:0]       ExAw;
  logic             ExMdStart;
  logic             ExBranchTaken;
  logic             MemWait;
  logic             PcWr;
  logic             IfIdWr;
  logic             IfIdFlush;
  logic             IdExFlush;
  logic             ExMemWr;
  logic             MemWbFlush;
  logic             MdBusy;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output IdRs, IdRt, IdUsesRs, IdUsesRt, IdMdRead, ExMemRead, ExAw,
           ExMdStart, ExBranchTaken, MemWait,
    input  PcWr, IfIdWr, IfIdFlush, IdExFlush, ExMemWr, MemWbFlush,
           MdBusy, StallCnt
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRs, IdUsesRt, IdMdRead, ExMemRead, ExAw,
           ExMdStart, ExBranchTaken, MemWait,
    output PcWr, IfIdWr, IfIdFlush, IdExFlush, ExMemWr, MemWbFlush,
           MdBusy, StallCnt
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Tracks how long the mult/div unit stays busy after a start.
// Latency: busy rises the cycle after a start and lasts MD_LATENCY cycles.
// A start is ignored while memory holds EX; the count keeps draining regardless.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_mem_wait,
  output logic o_busy
);

  logic [MD_CNT_W-1:0] r_md_cnt;

  // Load on a start that really leaves EX, otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (i_start && !i_mem_wait) begin
      r_md_cnt <= MD_CNT_W'(MD_LATENCY);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign o_busy = (r_md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use / mult-div stalls, memory-wait freeze, branch flush.
// Latency: all enables/flushes are combinational from state and inputs.
// Memory wait freezes everything upstream of MEM and defers any branch redirect.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_md_busy;
  logic             w_lu;
  logic             w_md;
  logic             w_pc_wr;
  logic             w_ifid_wr;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic             w_exmem_wr;
  logic             w_memwb_flush;

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (bus.ExMdStart),
    .i_mem_wait(bus.MemWait),
    .o_busy    (w_md_busy)
  );

  // In LU_STALL the EX slot holds the inserted bubble, so a load-use match is
  // stale and must not stretch the stall beyond one cycle.
  assign w_lu = bus.ExMemRead && (bus.ExAw != REG_ZERO) && (r_state != LU_STALL) &&
                (reg_match(bus.IdUsesRs, bus.IdRs, bus.ExAw) ||
                 reg_match(bus.IdUsesRt, bus.IdRt, bus.ExAw));

  // A start in EX this cycle counts as busy for the instruction behind it.
  assign w_md = bus.IdMdRead && (w_md_busy || bus.ExMdStart);

  // Prioritised pipeline control and next-state selection.
  always_comb begin
    w_pc_wr       = 1'b1;
    w_ifid_wr     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_wr    = 1'b1;
    w_memwb_flush = 1'b0;
    w_next_state  = RUN;
    if (!rst_n) begin
      w_pc_wr       = 1'b0;
      w_ifid_wr     = 1'b0;
      w_exmem_wr    = 1'b0;
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_memwb_flush = 1'b1;
    end else if (bus.MemWait) begin
      w_pc_wr       = 1'b0;
      w_ifid_wr     = 1'b0;
      w_exmem_wr    = 1'b0;
      w_memwb_flush = 1'b1;
      w_next_state  = MEM_HOLD;
    end else if (bus.ExBranchTaken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
    end else if (w_lu || w_md) begin
      w_pc_wr       = 1'b0;
      w_ifid_wr     = 1'b0;
      w_idex_flush  = 1'b1;
      w_next_state  = w_lu ? LU_STALL : RUN;
    end
  end

  // State register; reset always lands in RUN with an empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_wr && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.PcWr       = w_pc_wr;
  assign bus.IfIdWr     = w_ifid_wr;
  assign bus.IfIdFlush  = w_ifid_flush;
  assign bus.IdExFlush  = w_idex_flush;
  assign bus.ExMemWr    = w_exmem_wr;
  assign bus.MemWbFlush = w_memwb_flush;
  assign bus.MdBusy     = w_md_busy;
  assign bus.StallCnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expectations are queued when
// stimulus is applied and compared when outputs settle at the falling edge.
// A narrow stall counter is used so saturation is reachable quickly.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 4;
  // Control vector order: {PcWr, IfIdWr, IfIdFlush, IdExFlush, ExMemWr, MemWbFlush}
  localparam logic [5:0] C_RUN   = 6'b110010;
  localparam logic [5:0] C_STALL = 6'b000110;
  localparam logic [5:0] C_BR    = 6'b111110;
  localparam logic [5:0] C_MEM   = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b001101;

  typedef struct {
    string            name;
    logic [5:0]       ctl;
    logic             busy;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  exp_t             sb[$];
  logic [CNT_W-1:0] exp_stall;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .MD_LATENCY(8),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [5:0] ctl_now();
    return {bus.PcWr, bus.IfIdWr, bus.IfIdFlush, bus.IdExFlush, bus.ExMemWr, bus.MemWbFlush};
  endfunction

  task automatic clear_inputs();
    bus.IdRs = 5'd0; bus.IdRt = 5'd0; bus.IdUsesRs = 1'b0; bus.IdUsesRt = 1'b0;
    bus.IdMdRead = 1'b0; bus.ExMemRead = 1'b0; bus.ExAw = 5'd0; bus.ExMdStart = 1'b0;
    bus.ExBranchTaken = 1'b0; bus.MemWait = 1'b0;
  endtask

  // Queue this cycle's expectation, advance the model counter, then pop and
  // compare once the combinational outputs have settled.
  task automatic step(input string name, input logic [5:0] ctl, input logic busy);
    exp_t e;
    e.name = name; e.ctl = ctl; e.busy = busy; e.stall = exp_stall;
    sb.push_back(e);
    if (!ctl[5] && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (ctl_now() !== e.ctl) begin
      n_bad++;
      $display("FAIL %s ctl: got %b want %b", e.name, ctl_now(), e.ctl);
    end
    n_cmp++;
    if (bus.MdBusy !== e.busy) begin
      n_bad++;
      $display("FAIL %s MdBusy: got %b want %b", e.name, bus.MdBusy, e.busy);
    end
    n_cmp++;
    if (bus.StallCnt !== e.stall) begin
      n_bad++;
      $display("FAIL %s StallCnt: got %0d want %0d", e.name, bus.StallCnt, e.stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl_now() !== C_RST) begin
      n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl_now(), C_RST);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ctl_now() !== C_RST || bus.MdBusy !== 1'b0 || bus.StallCnt !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got ctl=%b busy=%b cnt=%0d want ctl=%b busy=0 cnt=0",
               ctl_now(), bus.MdBusy, bus.StallCnt, C_RST);
    end
    rst_n = 1'b1;
    exp_stall = '0;
    step("idle0", C_RUN, 1'b0);
    step("idle1", C_RUN, 1'b0);
  endtask

  task automatic test_load_use();
    bus.ExMemRead = 1'b1; bus.ExAw = 5'd8; bus.IdRs = 5'd8; bus.IdUsesRs = 1'b1;
    step("lu_stall", C_STALL, 1'b0);
    step("lu_one_bubble", C_RUN, 1'b0);
    n_cmp++;
    if (bus.StallCnt !== 4'd1) begin
      n_bad++; $display("FAIL lu_count: got %0d want 1", bus.StallCnt);
    end
    bus.IdUsesRs = 1'b0;
    step("lu_rs_not_used", C_RUN, 1'b0);
    bus.IdRs = 5'd3; bus.IdRt = 5'd8; bus.IdUsesRt = 1'b1;
    step("lu_rt", C_STALL, 1'b0);
    clear_inputs();
    step("lu_rt_after", C_RUN, 1'b0);
  endtask

  task automatic test_reg0();
    bus.ExMemRead = 1'b1; bus.ExAw = 5'd0; bus.IdRs = 5'd0; bus.IdRt = 5'd0;
    bus.IdUsesRs = 1'b1; bus.IdUsesRt = 1'b1;
    step("reg0_a", C_RUN, 1'b0);
    step("reg0_b", C_RUN, 1'b0);
    n_cmp++;
    if (bus.StallCnt !== 4'd2) begin
      n_bad++; $display("FAIL reg0_count: got %0d want 2", bus.StallCnt);
    end
    clear_inputs();
  endtask

  task automatic test_branch_over_lu();
    bus.ExMemRead = 1'b1; bus.ExAw = 5'd8; bus.IdRs = 5'd8; bus.IdUsesRs = 1'b1;
    bus.ExBranchTaken = 1'b1;
    step("br_over_lu", C_BR, 1'b0);
    clear_inputs();
    step("br_after", C_RUN, 1'b0);
  endtask

  task automatic test_md_busy();
    bus.ExMdStart = 1'b1;
    step("md_start", C_RUN, 1'b0);
    bus.ExMdStart = 1'b0; bus.IdMdRead = 1'b1;
    for (int i = 0; i < 8; i++) step($sformatf("md_wait%0d", i), C_STALL, 1'b1);
    step("md_release", C_RUN, 1'b0);
    n_cmp++;
    if (bus.StallCnt !== 4'd10) begin
      n_bad++; $display("FAIL md_count: got %0d want 10", bus.StallCnt);
    end
    // Start and dependent read in the same cycle, then a restart while busy.
    bus.ExMdStart = 1'b1;
    step("md_start_read", C_STALL, 1'b0);
    bus.ExMdStart = 1'b0; bus.IdMdRead = 1'b0;
    step("md_busy_a", C_RUN, 1'b1);
    step("md_busy_b", C_RUN, 1'b1);
    bus.ExMdStart = 1'b1;
    step("md_reload", C_RUN, 1'b1);
    bus.ExMdStart = 1'b0;
    for (int i = 0; i < 8; i++) step($sformatf("md_reloaded%0d", i), C_RUN, 1'b1);
    step("md_reload_done", C_RUN, 1'b0);
  endtask

  task automatic test_mem_wait();
    bus.MemWait = 1'b1; bus.ExBranchTaken = 1'b1; bus.ExMdStart = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("mem_hold%0d", i), C_MEM, 1'b0);
    bus.MemWait = 1'b0; bus.ExMdStart = 1'b0;
    step("mem_branch", C_BR, 1'b0);
    clear_inputs();
    step("mem_after", C_RUN, 1'b0);
    // Mult/div keeps draining while memory holds the pipe.
    bus.ExMdStart = 1'b1;
    step("mem_md_start", C_RUN, 1'b0);
    bus.ExMdStart = 1'b0; bus.MemWait = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("mem_md_hold%0d", i), C_MEM, 1'b1);
    bus.MemWait = 1'b0;
    for (int i = 0; i < 5; i++) step($sformatf("mem_md_tail%0d", i), C_RUN, 1'b1);
    step("mem_md_idle", C_RUN, 1'b0);
  endtask

  task automatic test_saturation();
    bus.MemWait = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("sat%0d", i), C_MEM, 1'b0);
    n_cmp++;
    if (bus.StallCnt !== 4'd15) begin
      n_bad++; $display("FAIL sat_count: got %0d want 15", bus.StallCnt);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    bus.ExMdStart = 1'b1;
    step("prerst_start", C_RUN, 1'b0);
    bus.ExMdStart = 1'b0; bus.MemWait = 1'b1;
    step("prerst_hold", C_MEM, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl_now() !== C_RST) begin
      n_bad++; $display("FAIL arst_ctl: got %b want %b", ctl_now(), C_RST);
    end
    n_cmp++;
    if (bus.MdBusy !== 1'b0 || dut.u_md.r_md_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL arst_md: got busy=%b cnt=%0d want busy=0 cnt=0", bus.MdBusy, dut.u_md.r_md_cnt);
    end
    n_cmp++;
    if (bus.StallCnt !== '0) begin
      n_bad++; $display("FAIL arst_stall: got %0d want 0", bus.StallCnt);
    end
    n_cmp++;
    if (dut.r_state !== RUN) begin
      n_bad++; $display("FAIL arst_state: got %0d want %0d", dut.r_state, RUN);
    end
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stall = '0;
    step("post_rst", C_RUN, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0();
    test_branch_over_lu();
    test_md_busy();
    test_mem_wait();
    test_saturation();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing unit for the 5-stage CPU, sitting beside the forwarding unit.
- Detects what forwarding cannot resolve: load-use hazards, reads of a busy multiply/divide unit, and data-memory wait.
- Resolves taken-branch redirects.
- Drives the PC and pipeline-register write enables and flushes, and keeps a saturating stall-cycle counter.

Parameters:
- MD_LATENCY, 8, cycles the mult/div unit is busy after a start (1..15).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- IdRs  input  5  rs field of the instruction in ID
- IdRt  input  5  rt field of the instruction in ID
- IdUsesRs  input  1  ID instruction reads rs
- IdUsesRt  input  1  ID instruction reads rt
- IdMdRead  input  1  ID instruction is mfhi/mflo/mult/div (needs MD idle)
- ExMemRead  input  1  EX instruction is a load
- ExAw  input  5  EX destination register
- ExMdStart  input  1  EX instruction starts mult/div this cycle
- ExBranchTaken  input  1  branch/jump in EX resolved taken
- MemWait  input  1  data memory not ready; MEM access must hold
- PcWr  output  1  PC write enable
- IfIdWr  output  1  IF/ID write enable
- IfIdFlush  output  1  IF/ID load bubble
- IdExFlush  output  1  ID/EX load bubble
- ExMemWr  output  1  EX/MEM write enable
- MemWbFlush  output  1  MEM/WB load bubble
- MdBusy  output  1  mult/div busy
- StallCnt  output  CNT_W  stall cycles since reset

Behaviour:
- States: RUN, LU_STALL, MEM_HOLD. MD busy is tracked by a separate 4-bit down-counter MdCnt.
- Reset (rst_n=0, asynchronous):
  - State RUN, MdCnt=0, StallCnt=0.
  - Outputs forced to PcWr=0, IfIdWr=0, ExMemWr=0, IfIdFlush=1, IdExFlush=1, MemWbFlush=1, MdBusy=0.
  - Reset deasserted mid-stall resumes in RUN with an empty pipe.
- Hazard terms, combinational:
  - lu = ExMemRead & ExAw!=0 & ((IdUsesRs & IdRs==ExAw) | (IdUsesRt & IdRt==ExAw)).
  - md = IdMdRead & (MdCnt!=0 | ExMdStart).
- Priority, highest first; outputs are combinational from state and inputs:
  1. MemWait=1:
     - Freeze: PcWr=IfIdWr=ExMemWr=0, MemWbFlush=1, other flushes 0.
     - Next state MEM_HOLD. Branch redirect is deferred, because the EX stage is held and ExBranchTaken stays asserted.
  2. ExBranchTaken=1:
     - PcWr=IfIdWr=ExMemWr=1, IfIdFlush=1, IdExFlush=1.
     - Overrides lu/md, since the ID instruction is squashed. Next state RUN.
  3. lu | md:
     - PcWr=IfIdWr=0, IdExFlush=1, ExMemWr=1.
     - Next state LU_STALL if lu, else RUN.
  4. Otherwise: all enables 1, flushes 0.
- State meanings:
  - LU_STALL is exactly one bubble. lu cannot recur in that cycle because EX now holds the bubble; md may still stall.
  - MEM_HOLD returns to RUN on the first cycle with MemWait=0; that cycle is evaluated normally.
- MdCnt:
  - Loads MD_LATENCY on ExMdStart when MemWait=0.
  - Otherwise decrements while nonzero, including during MemWait.
  - MdBusy = MdCnt!=0.
  - A start while busy reloads MD_LATENCY.
- StallCnt increments on every cycle with PcWr=0 and rst_n=1, and saturates at all-ones.
- Register 0 never causes a load-use stall.

Decomposition:
- Shared package constants: state encodings (RUN=2'd0, LU_STALL=2'd1, MEM_HOLD=2'd2), MD_LATENCY default, register-zero constant 5'd0.
- One natural sub-module: md_busy_counter (MdCnt load/decrement, MdBusy).

Test Plan:
- Load-use stall:
  - Stimulus: ExMemRead=1, ExAw=8, IdRs=8, IdUsesRs=1.
  - Response: PcWr=0, IfIdWr=0, IdExFlush=1 for exactly one cycle, then all enables 1; StallCnt=1.
- Load to register 0:
  - Stimulus: ExAw=0, IdRs=0.
  - Response: no stall; PcWr=1, StallCnt unchanged.
- Branch over load-use:
  - Stimulus: load-use condition and ExBranchTaken=1 in the same cycle.
  - Response: PcWr=1, IfIdFlush=1, IdExFlush=1, no stall.
- MD busy:
  - Stimulus: ExMdStart pulse, then IdMdRead=1 held.
  - Response: MdBusy high 8 cycles; PcWr=0 for those cycles, released when MdCnt reaches 0; StallCnt=8.
- Memory wait:
  - Stimulus: MemWait=1 for 3 cycles with ExBranchTaken=1.
  - Response: PcWr=ExMemWr=0, MemWbFlush=1 for 3 cycles; branch flush occurs on the 4th cycle.
- Async reset mid-MEM_HOLD:
  - Stimulus: rst_n low with no clock edge.
  - Response: outputs immediately show the reset values; MdCnt=0, StallCnt=0.
